// File: rtl/gpu_rect_addrgen.sv
// Framebuffer rectangle address generator: shift-add row offset, then raster-order beats over valid/ready.
// Optional screen clipping is compiled in with `define GPU_ADDRGEN_CLIP_EN.
module gpu_rect_addrgen #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int ADDR_BITS   = WIDTH_BITS + HEIGHT_BITS + 1,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   base,
    input  logic [WIDTH_BITS:0]    stride,
    input  logic [WIDTH_BITS-1:0]  x0,
    input  logic [WIDTH_BITS-1:0]  x1,
    input  logic [HEIGHT_BITS-1:0] y0,
    input  logic [HEIGHT_BITS-1:0] y1,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_BITS-1:0]   out_addr,
    output logic [WIDTH_BITS-1:0]  out_x,
    output logic [HEIGHT_BITS-1:0] out_y,
    output logic                   out_last,
    output logic                   done
);

    localparam int CW = $clog2(HEIGHT_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_RUN,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [ADDR_BITS-1:0]   row_base_q;
    logic [ADDR_BITS-1:0]   mcand_q;
    logic [HEIGHT_BITS-1:0] mplier_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [WIDTH_BITS:0]    stride_q;
    logic [WIDTH_BITS-1:0]  x0_q;
    logic [WIDTH_BITS-1:0]  x1_q;
    logic [WIDTH_BITS-1:0]  x_q;
    logic [HEIGHT_BITS-1:0] y0_q;
    logic [HEIGHT_BITS-1:0] y1_q;
    logic [HEIGHT_BITS-1:0] y_q;
    logic                   busy_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   done_q;

    logic [WIDTH_BITS-1:0]  x1_d;
    logic [HEIGHT_BITS-1:0] y1_d;
    logic                   empty_d;
    logic [ADDR_BITS-1:0]   prod_d;
    logic [ADDR_BITS-1:0]   row_next_d;
    logic [ADDR_BITS-1:0]   x0_ext;
    logic                   at_x_end;
    logic                   at_y_end;

    always_comb begin
        x1_d    = x1;
        y1_d    = y1;
        empty_d = 1'b0;
`ifdef GPU_ADDRGEN_CLIP_EN
        // Clamp first so an off-screen x1/y1 cannot by itself make the rect empty.
        if (x1 > WIDTH_BITS'(SCREEN_W - 1))
            x1_d = WIDTH_BITS'(SCREEN_W - 1);
        if (y1 > HEIGHT_BITS'(SCREEN_H - 1))
            y1_d = HEIGHT_BITS'(SCREEN_H - 1);
        if (({1'b0, x0} >= (WIDTH_BITS + 1)'(SCREEN_W)) ||
            ({1'b0, y0} >= (HEIGHT_BITS + 1)'(SCREEN_H)))
            empty_d = 1'b1;
`endif
        if ((x1_d < x0) || (y1_d < y0))
            empty_d = 1'b1;
    end

    always_comb begin
        prod_d     = row_base_q + (mplier_q[0] ? mcand_q : '0);
        row_next_d = row_base_q + ADDR_BITS'(stride_q);
        x0_ext     = ADDR_BITS'(x0_q);
        at_x_end   = (x_q == x1_q);
        at_y_end   = (y_q == y1_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_base_q <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            x_q        <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            y_q        <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x0_q       <= x0;
                        x1_q       <= x1_d;
                        y0_q       <= y0;
                        y1_q       <= y1_d;
                        stride_q   <= stride;
                        row_base_q <= base;
                        mcand_q    <= ADDR_BITS'(stride);
                        mplier_q   <= y0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        if (empty_d) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_MUL;
                        end
                    end
                end
                // HEIGHT_BITS add/shift steps, then one cycle to form the first pixel address.
                S_MUL: begin
                    if (cnt_q == CW'(HEIGHT_BITS)) begin
                        addr_q  <= row_base_q + x0_ext;
                        x_q     <= x0_q;
                        y_q     <= y0_q;
                        valid_q <= 1'b1;
                        last_q  <= (x0_q == x1_q) && (y0_q == y1_q);
                        state_q <= S_RUN;
                    end else begin
                        row_base_q <= prod_d;
                        mcand_q    <= mcand_q << 1;
                        mplier_q   <= mplier_q >> 1;
                        cnt_q      <= cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (!at_x_end) begin
                            x_q    <= x_q + WIDTH_BITS'(1);
                            addr_q <= addr_q + ADDR_BITS'(1);
                            last_q <= ((x_q + WIDTH_BITS'(1)) == x1_q) && at_y_end;
                        end else if (!at_y_end) begin
                            x_q        <= x0_q;
                            y_q        <= y_q + HEIGHT_BITS'(1);
                            row_base_q <= row_next_d;
                            addr_q     <= row_next_d + x0_ext;
                            last_q     <= (x0_q == x1_q) && ((y_q + HEIGHT_BITS'(1)) == y1_q);
                        end else begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_last  = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gpu_rect_addrgen.sv
// Directed bench for gpu_rect_addrgen: latency, stall hold, empty rect, ignored restarts, async reset, wrap, clip.
module tb_gpu_rect_addrgen;

    localparam int WB = 10;
    localparam int HB = 9;
    localparam int AB = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AB-1:0] base;
    logic [WB:0]   stride;
    logic [WB-1:0] x0, x1;
    logic [HB-1:0] y0, y1;
    logic          busy, out_valid, out_ready, out_last, done;
    logic [AB-1:0] out_addr;
    logic [WB-1:0] out_x;
    logic [HB-1:0] out_y;

    gpu_rect_addrgen #(
        .WIDTH_BITS (WB),
        .HEIGHT_BITS(HB),
        .ADDR_BITS  (AB),
        .SCREEN_W   (640),
        .SCREEN_H   (480)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .stride   (stride),
        .x0       (x0),
        .x1       (x1),
        .y0       (y0),
        .y1       (y1),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_last (out_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Beat monitor: a transfer is valid&ready just before the rising edge.
    int q_addr[$], q_x[$], q_y[$], q_last[$], beat_edge[$];
    int e_addr[$], e_x[$], e_y[$], e_last[$];
    int done_cnt, done_edge, busy_cycles, valid_seen;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_addr.push_back(int'(out_addr));
            q_x.push_back(int'(out_x));
            q_y.push_back(int'(out_y));
            q_last.push_back(int'(out_last));
            beat_edge.push_back(cyc + 1);
        end
        if (done) begin
            done_cnt++;
            done_edge = cyc;
        end
        if (busy) busy_cycles++;
        if (out_valid) valid_seen++;
    end

    task automatic clear_stats();
        q_addr.delete(); q_x.delete(); q_y.delete(); q_last.delete(); beat_edge.delete();
        done_cnt = 0; done_edge = -1; busy_cycles = 0; valid_seen = 0;
    endtask

    task automatic set_rect(input int b, input int s, input int ax0, input int ay0,
                            input int ax1, input int ay1);
        base   = AB'(b);
        stride = (WB + 1)'(s);
        x0     = WB'(ax0);
        y0     = HB'(ay0);
        x1     = WB'(ax1);
        y1     = HB'(ay1);
    endtask

    task automatic start_cmd(input int b, input int s, input int ax0, input int ay0,
                             input int ax1, input int ay1);
        set_rect(b, s, ax0, ay0, ax1, ay1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, (done_cnt > 0) ? 1 : 0, 1);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_count"}, q_addr.size(), e_addr.size());
        for (int i = 0; i < q_addr.size() && i < e_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), q_addr[i], e_addr[i]);
            check($sformatf("%s_x%0d", tag, i), q_x[i], e_x[i]);
            check($sformatf("%s_y%0d", tag, i), q_y[i], e_y[i]);
            check($sformatf("%s_last%0d", tag, i), q_last[i], e_last[i]);
        end
    endtask

    task automatic load_rect6();
        e_addr = '{642, 643, 644, 1282, 1283, 1284};
        e_x    = '{2, 3, 4, 2, 3, 4};
        e_y    = '{1, 1, 1, 2, 2, 2};
        e_last = '{0, 0, 0, 0, 0, 1};
    endtask

    initial begin
        int n;
        int nlast;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        set_rect(0, 0, 0, 0, 0, 0);
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", out_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic 3x2 rect with latency and done timing
        clear_stats(); load_rect6(); out_ready = 1'b1;
        start_cmd(0, 640, 2, 1, 4, 2);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("t1_latency", n, 10);
        wait_done("t1");
        check_beats("t1");
        check("t1_done_cnt", done_cnt, 1);
        if (beat_edge.size() == 6) check("t1_done_edge", done_edge, beat_edge[5]);
        else check("t1_beats_for_done_edge", beat_edge.size(), 6);

        // 2: three stalled cycles on the second beat
        clear_stats(); load_rect6(); out_ready = 1'b1;
        start_cmd(0, 640, 2, 1, 4, 2);
        wait_valid("t2");
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            check($sformatf("t2_stall_addr%0d", i), out_addr, 643);
            check($sformatf("t2_stall_x%0d", i), out_x, 3);
            check($sformatf("t2_stall_valid%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        wait_done("t2");
        check_beats("t2");

        // 3: empty rect (x1 < x0)
        clear_stats();
        start_cmd(0, 640, 5, 3, 4, 3);
        check("t3_busy_now", busy, 1);
        check("t3_done_now", done, 1);
        repeat (5) begin @(posedge clk); #1; end
        check("t3_valid_seen", valid_seen, 0);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_busy_cycles", busy_cycles, 1);

        // 4: start pulses during MUL and RUN are ignored
        clear_stats(); load_rect6(); out_ready = 1'b1;
        start_cmd(0, 640, 2, 1, 4, 2);
        repeat (3) begin @(posedge clk); #1; end
        start_cmd(0, 640, 0, 0, 0, 0);
        wait_valid("t4");
        start_cmd(0, 640, 0, 0, 0, 0);
        wait_done("t4");
        repeat (20) begin @(posedge clk); #1; end
        check_beats("t4");
        check("t4_done_cnt", done_cnt, 1);

        // 5: async reset mid-RUN, then a clean rerun
        clear_stats(); out_ready = 1'b1;
        start_cmd(0, 640, 2, 1, 4, 2);
        n = 0;
        while (q_addr.size() < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_two_beats", q_addr.size(), 2);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_addr", out_addr, 0);
        check("t5_rst_x", out_x, 0);
        check("t5_rst_y", out_y, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_last", out_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_stats(); load_rect6();
        start_cmd(0, 640, 2, 1, 4, 2);
        wait_done("t5");
        check_beats("t5");
        check("t5_done_cnt", done_cnt, 1);

        // 6: single pixel, odd stride, nonzero base
        clear_stats();
        e_addr = '{172}; e_x = '{7}; e_y = '{5}; e_last = '{1};
        start_cmd(100, 13, 7, 5, 7, 5);
        wait_done("t6");
        check_beats("t6");

        // 7: address wrap modulo 2^20
        clear_stats();
        e_addr = '{1048574, 1048575, 0, 1}; e_x = '{0, 1, 2, 3}; e_y = '{0, 0, 0, 0};
        e_last = '{0, 0, 0, 1};
        start_cmd(1048574, 640, 0, 0, 3, 0);
        wait_done("t7");
        check_beats("t7");

        // 8: rectangle extending past the screen edge
        clear_stats();
        start_cmd(0, 640, 638, 479, 700, 500);
        wait_done("t8");
        nlast = 0;
        foreach (q_last[i]) nlast += q_last[i];
        check("t8_last_cnt", nlast, 1);
`ifdef GPU_ADDRGEN_CLIP_EN
        check("t8_count", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            check("t8_addr0", q_addr[0], 307198);
            check("t8_addr1", q_addr[1], 307199);
            check("t8_last1", q_last[1], 1);
        end
`else
        check("t8_count", q_addr.size(), 1386);
        if (q_addr.size() == 1386) begin
            check("t8_first", q_addr[0], 307198);
            check("t8_lastaddr", q_addr[1385], 320700);
            check("t8_lastflag", q_last[1385], 1);
            check("t8_row1_start", q_addr[63], 307838);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpu_rect_addrgen.md
Name: gpu_rect_addrgen

Overview:
Parametrised framebuffer address generator for rectangle fills and blits. Replaces the fixed combinational row-offset lookup (y*WIDTH) with a sequential engine. Given a base address, a row stride and an inclusive rectangle (x0,y0)-(x1,y1), it emits one linear pixel address per accepted beat in raster order over a valid/ready stream. Sits between the GPU command decoder and the framebuffer write/read port.

Parameters:
WIDTH_BITS, 10, bits of x coordinate
HEIGHT_BITS, 9, bits of y coordinate
ADDR_BITS, 20, bits of linear address (default WIDTH_BITS+HEIGHT_BITS+1)
SCREEN_W, 640, screen width in pixels (used only by clip feature)
SCREEN_H, 480, screen height in pixels (used only by clip feature)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  command strobe, sampled in IDLE only
base  in  ADDR_BITS  framebuffer base address
stride  in  WIDTH_BITS+1  pixels per row
x0, x1  in  WIDTH_BITS  inclusive column bounds
y0, y1  in  HEIGHT_BITS  inclusive row bounds
busy  out  1  high in every state except IDLE
out_valid  out  1  address beat valid
out_ready  in  1  consumer accepts beat
out_addr  out  ADDR_BITS  linear pixel address
out_x  out  WIDTH_BITS  current column
out_y  out  HEIGHT_BITS  current row
out_last  out  1  high on final beat of rectangle
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset (async, any state): state=IDLE; busy, out_valid, out_last, done = 0; out_addr, out_x, out_y = 0; internal regs cleared. Beat in flight is dropped.
- IDLE: start=1 registers all inputs. If x1<x0 or y1<y0 -> DONE (empty, no beats). Else -> MUL. start while busy=1 is ignored; no queueing.
- MUL: shift-add multiply row_base = base + y0*stride, one multiplier bit per cycle, exactly HEIGHT_BITS cycles. Then -> RUN with cur_addr = row_base + x0, x=x0, y=y0.
- RUN: out_valid=1. out_addr/out_x/out_y/out_last stable while out_valid && !out_ready. On transfer (valid&ready):
  - x<x1: x+=1, cur_addr+=1.
  - x==x1, y<y1: x=x0, y+=1, row_base+=stride, cur_addr=row_base+stride+x0.
  - x==x1, y==y1 (out_last=1): out_valid drops next cycle -> DONE.
- DONE: done=1 for one cycle, busy still 1; -> IDLE.
- First beat presented HEIGHT_BITS+1 cycles after start edge; full-throughput thereafter (1 beat/cycle with out_ready held high, including across row change).
- All address arithmetic modulo 2^ADDR_BITS; wrap is silent.
- out_last = (x==x1 && y==y1) while out_valid; 0 otherwise.
- Single-pixel rect (x0==x1, y0==y1): exactly one beat with out_last=1.

Optional Feature:
GPU_ADDRGEN_CLIP_EN
- Defined: at start, x1 clamped to SCREEN_W-1, y1 to SCREEN_H-1; if x0>=SCREEN_W or y0>=SCREEN_H rect is empty (-> DONE, no beats). Clamp occurs before the emptiness check.
- Undefined: coordinates used unmodified; SCREEN_W/SCREEN_H unused.

Test Plan:
- base=0, stride=640, rect (2,1)-(4,2), out_ready=1 -> first valid 10 cycles after start; addrs 642,643,644,1282,1283,1284; out_last only on 1284; done pulses once, 1 cycle after last transfer.
- Same rect, out_ready low for 3 cycles on 2nd beat -> out_addr holds 643, out_x=3 for all 3 stalled cycles; no beat skipped or duplicated.
- Rect (5,3)-(4,3) -> no out_valid ever; done pulses within 2 cycles of start; busy high for those cycles only.
- start re-pulsed with rect (0,0)-(0,0) during MUL and RUN of a 6-beat command -> ignored; exactly 6 beats and 1 done.
- rst asserted mid-RUN after 2 beats -> outputs 0 immediately (async); new start after release runs full command from scratch.
- With GPU_ADDRGEN_CLIP_EN, base=0, stride=640, rect (638,479)-(700,500) -> beats 307198, 307199 (last); without macro -> 63*22=1386 beats, last addr = 500*640+700 mod 2^20 = 320700.
